// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The optional statistics feature is enabled by defining DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    // Which requester drives the dmem port in the current cycle.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_PER = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_STARVE_LIMIT = 8;
    localparam int WAIT_CNT_W       = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation counter: counts consecutive cycles the peripheral has waited
// with its request up and raises force_gnt once the limit is reached.
// (The output cannot be called "force" because that is a keyword.)
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  per_req,
    input  logic                  per_gnt,
    output logic                  force_gnt,
    output logic [WAIT_CNT_W-1:0] wait_cnt
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(STARVE_LIMIT);

    // Clear on grant or idle request, otherwise count up and hold at the limit.
    always_ff @(posedge clock) begin
        if (reset || per_gnt || !per_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Peripheral has waited long enough: it takes the port regardless of the CPU.
    always_comb begin
        force_gnt = (wait_cnt == LIMIT);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the processor memory stage and one
// peripheral requester. Processor has priority; the starvation counter
// forces a one-cycle peripheral slot (stalling the processor) after
// STARVE_LIMIT waiting cycles.
// Optional feature: define DMEM_ARB_STATS_EN for contention statistics.
//
// Peripheral handshake: per_req acts as valid and per_gnt as ready. An
// access transfers in any cycle where both are high; per_addr, per_wdata
// and per_we must hold steady while per_req is high and per_gnt is low.
// A granted read returns per_rdata with a one-cycle per_rvalid pulse on
// the following cycle; a granted write completes in the grant cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_wren,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              per_req,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    input  logic              per_we,
    output logic              per_gnt,
    output logic              per_rvalid,
    output logic [DATA_W-1:0] per_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_stalls,
    output logic [31:0]       stat_per_grants
`endif
);

    owner_e                owner;
    logic                  force_gnt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  rd_pend;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clock     (clock),
        .reset     (reset),
        .per_req   (per_req),
        .per_gnt   (per_gnt),
        .force_gnt (force_gnt),
        .wait_cnt  (wait_cnt)
    );

    // Owner selection and port mux; the CPU owns the port while in reset.
    always_comb begin
        owner       = OWN_CPU;
        mem_address = cpu_addr;
        mem_data    = cpu_data;
        mem_wren    = cpu_req & cpu_wren;
        per_gnt     = 1'b0;
        cpu_stall   = 1'b0;
        if (!reset && per_req && (!cpu_req || force_gnt)) begin
            owner = OWN_PER;
        end
        if (owner == OWN_PER) begin
            mem_address = per_addr;
            mem_data    = per_wdata;
            mem_wren    = per_we;
            per_gnt     = 1'b1;
            cpu_stall   = cpu_req;
        end
    end

    assign cpu_q      = mem_q;
    assign per_rvalid = rd_pend;

    // Peripheral read return: dmem answers on the falling edge, so mem_q
    // already holds the granted read data at the end of the grant cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            per_rdata <= '0;
        end else begin
            rd_pend <= per_gnt && !per_we;
            if (per_gnt && !per_we) begin
                per_rdata <= mem_q;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Contention statistics, free-running and wrapping at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_cpu_stalls <= '0;
            stat_per_grants <= '0;
        end else begin
            if (cpu_stall) stat_cpu_stalls <= stat_cpu_stalls + 32'd1;
            if (per_gnt)   stat_per_grants <= stat_per_grants + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a behavioural model.
// Define DMEM_ARB_STATS_EN to exercise the statistics counters.
module tb_dmem_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cpu_req, cpu_wren, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data, cpu_q;
  logic          per_req, per_we, per_gnt, per_rvalid;
  logic [AW-1:0] per_addr;
  logic [DW-1:0] per_wdata, per_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_wren;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   stat_cpu_stalls, stat_per_grants;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_wren(cpu_wren), .cpu_stall(cpu_stall), .cpu_q(cpu_q),
    .per_req(per_req), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_we(per_we), .per_gnt(per_gnt), .per_rvalid(per_rvalid),
    .per_rdata(per_rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu_stalls(stat_cpu_stalls), .stat_per_grants(stat_per_grants)
`endif
  );

  // dmem stand-in, clocked on the falling edge, read-before-write.
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  always @(negedge clk) begin
    mem_q <= dmem[mem_address];
    if (mem_wren) dmem[mem_address] <= mem_data;
  end

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;
  logic          model_on = 1'b0;
  logic          gnt_seen = 1'b0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rdata;
  int            waited;
  logic [31:0]   m_stalls, m_grants;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle model: ownership from the priority/starvation rules, memory
  // contents from an array, read returns from an expected queue.
  always @(negedge clk) begin
    logic          own_per, e_wren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, e_q;
    #2;
    gnt_seen = per_gnt;
    if (model_on) begin
      own_per = !reset && per_req && (!cpu_req || waited >= LIMIT);
      e_addr  = own_per ? per_addr : cpu_addr;
      e_data  = own_per ? per_wdata : cpu_data;
      e_wren  = own_per ? per_we : (cpu_req & cpu_wren);
      e_q     = ref_mem[e_addr];
      chk("m_gnt",   {31'd0, per_gnt},   {31'd0, own_per});
      chk("m_stall", {31'd0, cpu_stall}, {31'd0, own_per & cpu_req});
      chk("m_addr",  {20'd0, mem_address}, {20'd0, e_addr});
      chk("m_wren",  {31'd0, mem_wren},  {31'd0, e_wren});
      if (e_wren) chk("m_data", mem_data, e_data);
      chk("m_cpu_q", cpu_q, e_q);
      chk("m_rvalid", {31'd0, per_rvalid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) last_rdata = exp_q.pop_front();
      chk("m_rdata", per_rdata, last_rdata);
`ifdef DMEM_ARB_STATS_EN
      chk("m_stat_stalls", stat_cpu_stalls, m_stalls);
      chk("m_stat_grants", stat_per_grants, m_grants);
`endif
      // advance to the next cycle
      if (e_wren) ref_mem[e_addr] = e_data;
      if (reset) begin
        exp_q.delete();
        last_rdata = '0;
        waited = 0;
        m_stalls = 0;
        m_grants = 0;
      end else begin
        if (own_per && !per_we) exp_q.push_back(e_q);
        if (!per_req || own_per) waited = 0;
        else if (waited < LIMIT) waited++;
        if (own_per && cpu_req) m_stalls++;
        if (own_per) m_grants++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #3;
  endtask

  task automatic cpu_drive(input logic req, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    cpu_req = req; cpu_addr = a; cpu_wren = we; cpu_data = d;
  endtask

  task automatic per_drive(input logic req, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    per_req = req; per_addr = a; per_we = we; per_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    dmem[12'h010] = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    mem_q = '0;
    last_rdata = '0;
    waited = 0;
    m_stalls = 0;
    m_grants = 0;
    reset = 1'b1;
    cpu_drive(1'b0, 12'h123, 1'b0, 32'h0);
    per_drive(1'b0, 12'h000, 1'b0, 32'h0);

    // reset state
    step();
    model_on = 1'b1;
    step();
    samp();
    chk("rst_gnt",    {31'd0, per_gnt},    32'd0);
    chk("rst_stall",  {31'd0, cpu_stall},  32'd0);
    chk("rst_rvalid", {31'd0, per_rvalid}, 32'd0);
    chk("rst_rdata",  per_rdata, 32'd0);
    chk("rst_addr",   {20'd0, mem_address}, 32'h123);

    // idle processor, peripheral read of 0x010
    step(); reset = 1'b0;
    per_drive(1'b1, 12'h010, 1'b0, 32'h0);
    samp();
    chk("rd_gnt", {31'd0, per_gnt}, 32'd1);
    chk("rd_addr", {20'd0, mem_address}, 32'h010);
    step(); per_drive(1'b0, 12'h000, 1'b0, 32'h0);
    samp();
    chk("rd_rvalid", {31'd0, per_rvalid}, 32'd1);
    chk("rd_rdata", per_rdata, 32'hDEADBEEF);
    step();
    samp();
    chk("rd_rvalid_pulse", {31'd0, per_rvalid}, 32'd0);

    // continuous cpu_req: forced grant exactly at cycle LIMIT
    for (int k = 0; k <= LIMIT + 1; k++) begin
      step();
      cpu_drive(1'b1, 12'h005, 1'b0, 32'h0);
      per_drive(k <= LIMIT, 12'h011, 1'b0, 32'h0);
      samp();
      chk($sformatf("starve_gnt_%0d", k),   {31'd0, per_gnt},   {31'd0, k == LIMIT});
      chk($sformatf("starve_stall_%0d", k), {31'd0, cpu_stall}, {31'd0, k == LIMIT});
    end
    chk("starve_resume_addr", {20'd0, mem_address}, 32'h005);

    // peripheral write 0x020 = 0x42, then processor lw 0x020
    step();
    cpu_drive(1'b0, 12'h000, 1'b0, 32'h0);
    per_drive(1'b1, 12'h020, 1'b1, 32'h42);
    samp();
    chk("wr_gnt",  {31'd0, per_gnt},  32'd1);
    chk("wr_wren", {31'd0, mem_wren}, 32'd1);
    chk("wr_data", mem_data, 32'h42);
    step();
    per_drive(1'b0, 12'h000, 1'b0, 32'h0);
    cpu_drive(1'b1, 12'h020, 1'b0, 32'h0);
    samp();
    chk("wr_no_rvalid", {31'd0, per_rvalid}, 32'd0);
    chk("wr_cpu_q", cpu_q, 32'h42);

    // simultaneous writes to 0x030: processor first, peripheral lands later
    step();
    cpu_drive(1'b1, 12'h030, 1'b1, 32'd7);
    per_drive(1'b1, 12'h030, 1'b1, 32'd9);
    samp();
    chk("both_gnt",  {31'd0, per_gnt}, 32'd0);
    chk("both_data", mem_data, 32'd7);
    step();
    cpu_drive(1'b0, 12'h000, 1'b0, 32'h0);
    samp();
    chk("both_late_gnt",  {31'd0, per_gnt}, 32'd1);
    chk("both_late_data", mem_data, 32'd9);
    step();
    per_drive(1'b0, 12'h000, 1'b0, 32'h0);
    cpu_drive(1'b1, 12'h030, 1'b0, 32'h0);
    samp();
    chk("both_final_q", cpu_q, 32'd9);
    chk("both_final_mem", dmem[12'h030], 32'd9);

    // reset right after a peripheral read grant
    step();
    cpu_drive(1'b0, 12'h000, 1'b0, 32'h0);
    per_drive(1'b1, 12'h010, 1'b0, 32'h0);
    samp();
    chk("rr_gnt", {31'd0, per_gnt}, 32'd1);
    step();
    reset = 1'b1;
    cpu_drive(1'b1, 12'h001, 1'b0, 32'h0);
    per_drive(1'b1, 12'h011, 1'b0, 32'h0);
    samp();
    for (int k = 0; k <= LIMIT; k++) begin
      step();
      reset = 1'b0;
      samp();
      if (k == 0) begin
        chk("rr_rvalid", {31'd0, per_rvalid}, 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("rr_stat_stalls", stat_cpu_stalls, 32'd0);
        chk("rr_stat_grants", stat_per_grants, 32'd0);
`endif
      end
      chk($sformatf("rr_wait_gnt_%0d", k), {31'd0, per_gnt}, {31'd0, k == LIMIT});
    end

    // 3 forced grants then 5 idle grants
    step();
    reset = 1'b1;
    cpu_drive(1'b0, 12'h000, 1'b0, 32'h0);
    per_drive(1'b0, 12'h000, 1'b0, 32'h0);
    step();
    reset = 1'b0;
    cpu_drive(1'b1, 12'h002, 1'b0, 32'h0);
    per_drive(1'b1, 12'h003, 1'b0, 32'h0);
    repeat (3 * (LIMIT + 1) - 1) step();
    step();
    cpu_drive(1'b0, 12'h000, 1'b0, 32'h0);
    repeat (4) step();
    step();
    per_drive(1'b0, 12'h000, 1'b0, 32'h0);
    samp();
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stalls", stat_cpu_stalls, 32'd3);
    chk("stat_grants", stat_per_grants, 32'd8);
`endif

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic busy;
      step();
      busy  = ((i / 250) % 2) == 1;
      reset = ($urandom_range(0, 199) == 0);
      cpu_drive(busy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0),
                AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
      if (!per_req || gnt_seen) begin
        per_drive(1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom);
      end
    end
    step();
    samp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
